// File: rtl/spi_ram_slave_burst.sv
// SPI slave with on-chip RAM: command decode, separate write/read pointers, burst transfers.
// Define SPI_PARITY_EN to add an even-parity bit after every data word in both directions.
module spi_ram_slave_burst #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic ss_n,
   input  logic MOSI,
   output logic MISO,
   output logic err
);

`ifdef SPI_PARITY_EN
   localparam int WBITS = DATA_W + 1;
`else
   localparam int WBITS = DATA_W;
`endif
   localparam int MAXW  = (WBITS > ADDR_W) ? WBITS : ADDR_W;
   localparam int RX_W  = MAXW - 1;
   localparam int CNT_W = $clog2(MAXW + 1);
   localparam int IDX_W = $clog2(DEPTH);

   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WBITS - 1);
`ifdef SPI_PARITY_EN
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
`endif

   typedef enum logic [2:0] {IDLE, CMD, WADDR, WDATA, RADDR, TURN, RDATA, DONE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    bit_cnt;
   logic [ADDR_W-1:0]   wr_addr;
   logic [ADDR_W-1:0]   rd_addr;
   logic [RX_W-1:0]     rx_shift;
   logic [DATA_W-2:0]   tx_shift;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   wdata;
   logic                word_end;
   logic                we;
   logic                par_err;
   logic                abort;
`ifdef SPI_PARITY_EN
   logic                tx_par;
`endif

   // Pointers may hold values >= DEPTH; they are folded into range on use.
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(int'(a) % DEPTH);
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      logic [IDX_W-1:0] i;
      i = wrap_idx(a);
      return (int'(i) == DEPTH - 1) ? '0 : ADDR_W'(i) + 1'b1;
   endfunction

   assign rd_data  = mem[wrap_idx(rd_addr)];
   assign word_end = (state == WDATA) && !ss_n && (bit_cnt == WORD_LAST);

`ifdef SPI_PARITY_EN
   assign wdata   = rx_shift[DATA_W-1:0];
   assign we      = word_end && ((^rx_shift[DATA_W-1:0]) == MOSI);
   assign par_err = word_end && ((^rx_shift[DATA_W-1:0]) != MOSI);
`else
   assign wdata   = {rx_shift[DATA_W-2:0], MOSI};
   assign we      = word_end;
   assign par_err = 1'b0;
`endif

   assign abort = ss_n && ((state == CMD) || (state == WADDR) || (state == RADDR) ||
                           (((state == WDATA) || (state == RDATA)) && (bit_cnt != '0)));

   // Datapath: shift registers and RAM, no reset.
   always_ff @(posedge clk) begin
      rx_shift <= {rx_shift[RX_W-2:0], MOSI};
      if (we)
         mem[wrap_idx(wr_addr)] <= wdata;
      if (state == TURN) begin
         tx_shift <= rd_data[DATA_W-2:0];
`ifdef SPI_PARITY_EN
         tx_par   <= ^rd_data;
`endif
      end else if (state == RDATA) begin
         tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
      end
   end

   // Control FSM with registered MISO/err.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         wr_addr <= '0;
         rd_addr <= '0;
         MISO    <= 1'b0;
         err     <= 1'b0;
      end else begin
         err  <= abort | par_err;
         MISO <= 1'b0;
         if (ss_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state   <= CMD;
                  bit_cnt <= '0;
               end
               CMD: begin
                  if (bit_cnt == CMD_LAST) begin
                     bit_cnt <= '0;
                     case ({rx_shift[0], MOSI})
                        2'b00:   state <= WADDR;
                        2'b01:   state <= WDATA;
                        2'b10:   state <= RADDR;
                        default: state <= TURN;
                     endcase
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               WADDR, RADDR: begin
                  if (bit_cnt == ADDR_LAST) begin
                     if (state == WADDR)
                        wr_addr <= {rx_shift[ADDR_W-2:0], MOSI};
                     else
                        rd_addr <= {rx_shift[ADDR_W-2:0], MOSI};
                     bit_cnt <= '0;
                     state   <= DONE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               WDATA: begin
                  if (bit_cnt == WORD_LAST) begin
                     bit_cnt <= '0;
                     if (we)
                        wr_addr <= next_addr(wr_addr);
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               TURN: begin
                  MISO    <= rd_data[DATA_W-1];
                  bit_cnt <= '0;
                  state   <= RDATA;
               end
               RDATA: begin
                  if (bit_cnt == WORD_LAST) begin
                     rd_addr <= next_addr(rd_addr);
                     bit_cnt <= '0;
                     state   <= TURN;
`ifdef SPI_PARITY_EN
                  end else if (bit_cnt == DATA_LAST) begin
                     MISO    <= tx_par;
                     bit_cnt <= bit_cnt + 1'b1;
`endif
                  end else begin
                     MISO    <= tx_shift[DATA_W-2];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               DONE: ;
            endcase
         end
      end
   end

endmodule
